// File: rtl/led_glow.sv
`default_nettype none
// ============================================================================
//  Module      : led_glow
//  Description : Turns a one-hot LED walker position into PWM LED drive with
//                a fading trail. Each LED has an 8-bit brightness register
//                that loads to full on a walker hit and decays geometrically
//                every DECAY_DIV clocks. The PWM output compares brightness
//                against a free-running 8-bit counter.
//  Options     : LEDGLOW_ONEHOT_CHECK_EN - when defined, non-zero inputs that
//                are not one-hot are rejected (no load) and flagged on o_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_glow #(
    parameter int unsigned DECAY_DIV   = 1000,
    parameter int unsigned DECAY_SHIFT = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_led,
    output logic [7:0] o_led,
    output logic       o_err
);

    localparam logic [31:0] c_decay_reload = 32'(DECAY_DIV - 32'd1);

    logic [7:0][7:0] r_bright;
    logic [7:0][7:0] w_bright_nxt;
    logic [7:0]      r_pwm_cnt;
    logic [31:0]     r_decay_cnt;
    logic            w_tick;
    logic [7:0]      w_load;
    logic [7:0]      w_led_nxt;
    logic [7:0]      w_shifted;
    logic [7:0]      w_step;

    assign w_tick = (r_decay_cnt == 32'd0);

`ifdef LEDGLOW_ONEHOT_CHECK_EN
    logic w_reject;

    // A non-zero input with more than one bit set is not a valid walker position.
    assign w_reject = (i_led != 8'd0) && ((i_led & (i_led - 8'd1)) != 8'd0);
    assign w_load   = w_reject ? 8'd0 : i_led;

    // Flag a rejected input for exactly one cycle after it is seen.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_err <= 1'b0;
        end else begin
            o_err <= w_reject;
        end
    end
`else
    assign w_load = i_led;
    assign o_err  = 1'b0;
`endif

    // Per-LED next brightness (load beats decay) and PWM compare on current state.
    always_comb begin
        w_bright_nxt = r_bright;
        w_led_nxt    = 8'd0;
        w_shifted    = 8'd0;
        w_step       = 8'd0;
        for (int k = 0; k < 8; k++) begin
            w_shifted = r_bright[k] >> DECAY_SHIFT;
            // Small values would never reach zero with a pure shift; force a step of 1.
            w_step    = (w_shifted == 8'd0) ? 8'd1 : w_shifted;
            if (w_load[k]) begin
                w_bright_nxt[k] = 8'hFF;
            end else if (w_tick && (r_bright[k] != 8'd0)) begin
                w_bright_nxt[k] = r_bright[k] - w_step;
            end
            // Full scale is forced on so 255 does not blink when the counter hits 255.
            w_led_nxt[k] = (r_bright[k] == 8'hFF) || (r_pwm_cnt < r_bright[k]);
        end
    end

    // Brightness registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bright <= '0;
        end else begin
            r_bright <= w_bright_nxt;
        end
    end

    // Free-running PWM counter, wraps naturally at 8 bits.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pwm_cnt <= 8'd0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end
    end

    // Decay prescaler: counts down to zero, tick while zero, then reloads.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_decay_cnt <= c_decay_reload;
        end else if (w_tick) begin
            r_decay_cnt <= c_decay_reload;
        end else begin
            r_decay_cnt <= r_decay_cnt - 32'd1;
        end
    end

    // Registered LED drive.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_led <= 8'd0;
        end else begin
            o_led <= w_led_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_glow.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_led_glow
//  Description : Self-checking bench for led_glow: table of directed vectors
//                plus hand-written sequences for the multi-cycle corners.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_glow;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] led_in;
    logic [7:0] led_out;
    logic       err;
    logic       rst2;
    logic [7:0] led_in2;
    logic [7:0] led_out2;
    logic       err2;

    int n_checks = 0;
    int n_pass   = 0;
    int ecount   = 0;

    always #5 clk = ~clk;

    led_glow #(.DECAY_DIV(4), .DECAY_SHIFT(2)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_led   (led_in),
        .o_led   (led_out),
        .o_err   (err)
    );

    // Slow-decay instance so a brightness level can be held for a full PWM period.
    led_glow #(.DECAY_DIV(600), .DECAY_SHIFT(1)) dut2 (
        .i_clk   (clk),
        .i_reset (rst2),
        .i_led   (led_in2),
        .o_led   (led_out2),
        .o_err   (err2)
    );

    typedef struct packed {
        logic [7:0]  led;
        logic [63:0] bright;
        logic [7:0]  oled;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ecount++;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        led_in = 8'h00;
        step();
        step();
        rst    = 1'b0;
        ecount = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi0;
        int hi1;

        // Expected brightness packed as {b7,...,b0}; o_led uses brightness before each edge.
        vecs[0]  = '{8'h01, 64'h0000_0000_0000_00FF, 8'h00};
        vecs[1]  = '{8'h00, 64'h0000_0000_0000_00FF, 8'h01};
        vecs[2]  = '{8'h04, 64'h0000_0000_00FF_00FF, 8'h01};
        vecs[3]  = '{8'h04, 64'h0000_0000_00FF_00C0, 8'h05};
        vecs[4]  = '{8'h04, 64'h0000_0000_00FF_00C0, 8'h05};
        vecs[5]  = '{8'h00, 64'h0000_0000_00FF_00C0, 8'h05};
        vecs[6]  = '{8'h00, 64'h0000_0000_00FF_00C0, 8'h05};
        vecs[7]  = '{8'h00, 64'h0000_0000_00C0_0090, 8'h05};
        vecs[8]  = '{8'h80, 64'hFF00_0000_00C0_0090, 8'h05};
        vecs[9]  = '{8'h00, 64'hFF00_0000_00C0_0090, 8'h85};
        vecs[10] = '{8'h00, 64'hFF00_0000_00C0_0090, 8'h85};
        vecs[11] = '{8'h00, 64'hC000_0000_0090_006C, 8'h85};
        vecs[12] = '{8'h00, 64'hC000_0000_0090_006C, 8'h85};
        vecs[13] = '{8'h00, 64'hC000_0000_0090_006C, 8'h85};
        vecs[14] = '{8'h00, 64'hC000_0000_0090_006C, 8'h85};
        vecs[15] = '{8'h00, 64'h9000_0000_006C_0051, 8'h85};

        rst     = 1'b1;
        led_in  = 8'h00;
        rst2    = 1'b1;
        led_in2 = 8'h00;

        // Reset state.
        do_reset();
        check("rst_bright", dut.r_bright, 64'd0);
        check("rst_pwm",    64'(dut.r_pwm_cnt), 64'd0);
        check("rst_dcnt",   64'(dut.r_decay_cnt), 64'd3);
        check("rst_oled",   64'(led_out), 64'h00);
        check("rst_err",    64'(err), 64'd0);

        // Walker load, decay trail, load-wins-over-tick, zero input.
        for (int i = 0; i < 16; i++) begin
            led_in = vecs[i].led;
            step();
            check($sformatf("vec%0d_bright", i), dut.r_bright, vecs[i].bright);
            check($sformatf("vec%0d_oled", i),   64'(led_out), 64'(vecs[i].oled));
            check($sformatf("vec%0d_err", i),    64'(err), 64'd0);
        end

        // Two bits set at once (edge 17, no tick).
        led_in = 8'h03;
        step();
`ifdef LEDGLOW_ONEHOT_CHECK_EN
        check("multi_bright", dut.r_bright, 64'h9000_0000_006C_0051);
        check("multi_err",    64'(err), 64'd1);
`else
        check("multi_bright", dut.r_bright, 64'h9000_0000_006C_FFFF);
        check("multi_err",    64'(err), 64'd0);
`endif
        led_in = 8'h00;
        step();
        check("multi_err_clear", 64'(err), 64'd0);

        // Decay tail to zero: bright[3] reaches 3 at tick 17 (edge 68).
        do_reset();
        led_in = 8'h08;
        step();
        led_in = 8'h00;
        while (ecount < 68) step();
        check("tail_3", dut.r_bright, 64'h0000_0000_0300_0000);
        while (ecount < 72) step();
        check("tail_2", dut.r_bright, 64'h0000_0000_0200_0000);
        while (ecount < 76) step();
        check("tail_1", dut.r_bright, 64'h0000_0000_0100_0000);
        while (ecount < 80) step();
        check("tail_0", dut.r_bright, 64'h0000_0000_0000_0000);
        while (ecount < 84) step();
        check("tail_0_hold", dut.r_bright, 64'h0000_0000_0000_0000);
        hi0 = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            hi0 += int'(led_out[3]);
        end
        check("tail_oled3_off", 64'(hi0), 64'd0);

        // Reset mid-fade with bright[5]=144, load and bad input applied together.
        do_reset();
        led_in = 8'h20;
        step();
        led_in = 8'h00;
        while (ecount < 9) step();
        check("fade_b5_144", dut.r_bright, 64'h0000_9000_0000_0000);
        check("fade_oled",   64'(led_out), 64'h20);
        rst    = 1'b1;
        led_in = 8'h23;
        step();
        check("midrst_bright", dut.r_bright, 64'd0);
        check("midrst_oled",   64'(led_out), 64'h00);
        check("midrst_pwm",    64'(dut.r_pwm_cnt), 64'd0);
        check("midrst_dcnt",   64'(dut.r_decay_cnt), 64'd3);
        check("midrst_err",    64'(err), 64'd0);
        rst    = 1'b0;
        led_in = 8'h20;
        ecount = 0;
        step();
        check("resume_load", dut.r_bright, 64'h0000_FF00_0000_0000);
        led_in = 8'h00;
        step();
        check("resume_oled", 64'(led_out), 64'h20);
        check("resume_pwm",  64'(dut.r_pwm_cnt), 64'd2);

        // PWM duty over full 256-clock windows on the slow instance.
        rst2    = 1'b0;
        led_in2 = 8'h02;
        ecount  = 0;
        step();
        led_in2 = 8'h00;
        hi0 = 0;
        hi1 = 0;
        for (int n = 0; n < 256; n++) begin
            step();
            hi1 += int'(led_out2[1]);
            hi0 += int'(led_out2[0]);
        end
        check("duty_255", 64'(hi1), 64'd256);
        check("duty_0",   64'(hi0), 64'd0);
        while (ecount < 600) step();
        check("slow_b1_128", 64'(dut2.r_bright[1]), 64'h80);
        hi1 = 0;
        for (int n = 0; n < 256; n++) begin
            step();
            hi1 += int'(led_out2[1]);
        end
        check("duty_128", 64'(hi1), 64'd128);
        while (ecount < 1200) step();
        check("slow_b1_64", 64'(dut2.r_bright[1]), 64'h40);
        hi1 = 0;
        for (int n = 0; n < 256; n++) begin
            step();
            hi1 += int'(led_out2[1]);
        end
        check("duty_64",  64'(hi1), 64'd64);
        check("slow_err", 64'(err2), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
